riscv_apu_disp_n: RTL and testbench

RISCV_APU_DISP_N -- requirements
Module: riscv_apu_disp_n

---
 rtl/riscv_apu_disp_n_if.sv | 23 ++
 rtl/riscv_apu_disp_n.sv | 176 +++++++++++++++++
 tb/tb_riscv_apu_disp_n.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_apu_disp_n_if.sv
// APU master handshake bundle between the dispatcher and the shared APU.
// req/gnt: a request is accepted in a cycle where req and gnt are both high.
// valid: the APU returns one result per cycle it is high. ready is always 1.
interface riscv_apu_disp_n_if;
  logic req;
  logic ready;
  logic gnt;
  logic valid;

  modport master (
    output req,
    output ready,
    input  gnt,
    input  valid
  );

  modport slave (
    input  req,
    input  ready,
    output gnt,
    output valid
  );
endinterface

// File: rtl/riscv_apu_disp_n.sv
// APU dispatcher: tracks the destinations of in-flight APU ops in an in-order
// FIFO, raises stalls and register dependencies, and routes writebacks.
module riscv_apu_disp_n #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int N_RD   = 3,
  parameter int N_WR   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,

  input  logic                       enable_i,
  input  logic [1:0]                 apu_lat_i,
  input  logic [ADDR_W-1:0]          apu_waddr_i,

  output logic [ADDR_W-1:0]          apu_waddr_o,
  output logic                       apu_wvalid_o,
  output logic                       apu_multicycle_o,
  output logic                       apu_singlecycle_o,

  output logic                       active_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       stall_o,
  output logic                       err_o,

  input  logic                       is_decoding_i,
  input  logic [N_RD*ADDR_W-1:0]     read_regs_i,
  input  logic [N_RD-1:0]            read_regs_valid_i,
  output logic                       read_dep_o,
  input  logic [N_WR*ADDR_W-1:0]     write_regs_i,
  input  logic [N_WR-1:0]            write_regs_valid_i,
  output logic                       write_dep_o,

  output logic                       perf_type_o,
  output logic                       perf_cont_o,
  output logic                       perf_full_o,

  riscv_apu_disp_n_if.master         apu_master
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] fifo_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        last_lat_q, last_lat_d;
  logic              err_q, err_d;

  logic active, stall_type, stall_full, stall_nack;
  logic valid_req, accepted, returned_req, push, pop, spurious;
  logic new_live;
  logic [DEPTH-1:0] live;
  logic read_hit, write_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Latency mixing rules: results must come back in order, so a shorter or
  // unknown-latency op may not overtake ops already in flight.
  assign active     = (count_q != '0);
  assign stall_type = enable_i & active &
                      ((apu_lat_i == 2'd1) |
                       ((apu_lat_i == 2'd2) & (last_lat_q == 2'd3)) |
                       (last_lat_q == 2'd0) |
                       (apu_lat_i == 2'd0));
  assign stall_full = enable_i & (count_q == CW'(DEPTH));

  assign valid_req    = enable_i & ~stall_type & ~stall_full;
  assign accepted     = valid_req & apu_master.gnt;
  assign stall_nack   = valid_req & ~apu_master.gnt;
  assign returned_req = accepted & apu_master.valid & ~active;
  assign pop          = apu_master.valid & active;
  assign push         = accepted & ~returned_req;
  assign spurious     = apu_master.valid & ~active & ~accepted;
  assign new_live     = valid_req & ~returned_req;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    last_lat_d = last_lat_q;
    err_d      = err_q | spurious;
    if (push) tail_d = ptr_inc(tail_q);
    if (pop)  head_d = ptr_inc(head_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (accepted) last_lat_d = apu_lat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      last_lat_q <= 2'd0;
      err_q      <= 1'b0;
      for (int j = 0; j < DEPTH; j++) fifo_q[j] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      last_lat_q <= last_lat_d;
      err_q      <= err_d;
      if (push) fifo_q[tail_q] <= apu_waddr_i;
    end
  end

  // A slot is live if it lies within count entries of head; the head itself
  // stops being a hazard in the cycle it writes back.
  always_comb begin
    int off;
    off  = 0;
    live = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (j >= int'(head_q)) off = j - int'(head_q);
      else                   off = j + DEPTH - int'(head_q);
      live[j] = (off < int'(count_q)) && !(pop && (off == 0));
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra       = '0;
    read_hit = 1'b0;
    for (int k = 0; k < N_RD; k++) begin
      ra = read_regs_i[k*ADDR_W +: ADDR_W];
      if (read_regs_valid_i[k]) begin
        for (int j = 0; j < DEPTH; j++)
          if (live[j] && (fifo_q[j] == ra)) read_hit = 1'b1;
        if (new_live && (apu_waddr_i == ra)) read_hit = 1'b1;
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] wa;
    wa        = '0;
    write_hit = 1'b0;
    for (int k = 0; k < N_WR; k++) begin
      wa = write_regs_i[k*ADDR_W +: ADDR_W];
      if (write_regs_valid_i[k]) begin
        for (int j = 0; j < DEPTH; j++)
          if (live[j] && (fifo_q[j] == wa)) write_hit = 1'b1;
        if (new_live && (apu_waddr_i == wa)) write_hit = 1'b1;
      end
    end
  end

  always_comb begin
    apu_waddr_o = '0;
    if (pop)               apu_waddr_o = fifo_q[head_q];
    else if (returned_req) apu_waddr_o = apu_waddr_i;
  end

  assign apu_wvalid_o      = pop | returned_req;
  assign apu_multicycle_o  = (last_lat_q == 2'd3) | ((last_lat_q == 2'd0) & active);
  assign apu_singlecycle_o = ~active;
  assign active_o          = active;
  assign count_o           = count_q;
  assign stall_o           = stall_type | stall_full | stall_nack;
  assign err_o             = err_q;
  assign read_dep_o        = read_hit & is_decoding_i;
  assign write_dep_o       = write_hit & is_decoding_i;
  assign perf_type_o       = stall_type;
  assign perf_cont_o       = stall_nack;
  assign perf_full_o       = stall_full;
  assign apu_master.req    = valid_req;
  assign apu_master.ready  = 1'b1;

endmodule

// File: tb/tb_riscv_apu_disp_n.sv
// Bench for riscv_apu_disp_n: directed scenarios plus random traffic checked
// against a queue-based reference model and a writeback scoreboard.
module tb_riscv_apu_disp_n;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;
  localparam int N_RD   = 3;
  localparam int N_WR   = 2;
  localparam int CW     = $clog2(DEPTH+1);

  // clock / reset
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic                   enable_i = 1'b0;
  logic [1:0]             apu_lat_i = '0;
  logic [ADDR_W-1:0]      apu_waddr_i = '0;
  logic [ADDR_W-1:0]      apu_waddr_o;
  logic                   apu_wvalid_o, apu_multicycle_o, apu_singlecycle_o;
  logic                   active_o, stall_o, err_o;
  logic [CW-1:0]          count_o;
  logic                   is_decoding_i = 1'b0;
  logic [N_RD*ADDR_W-1:0] read_regs_i = '0;
  logic [N_RD-1:0]        read_regs_valid_i = '0;
  logic                   read_dep_o;
  logic [N_WR*ADDR_W-1:0] write_regs_i = '0;
  logic [N_WR-1:0]        write_regs_valid_i = '0;
  logic                   write_dep_o;
  logic                   perf_type_o, perf_cont_o, perf_full_o;

  riscv_apu_disp_n_if apu_if ();

  riscv_apu_disp_n #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_WR(N_WR)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .enable_i(enable_i), .apu_lat_i(apu_lat_i), .apu_waddr_i(apu_waddr_i),
    .apu_waddr_o(apu_waddr_o), .apu_wvalid_o(apu_wvalid_o),
    .apu_multicycle_o(apu_multicycle_o), .apu_singlecycle_o(apu_singlecycle_o),
    .active_o(active_o), .count_o(count_o), .stall_o(stall_o), .err_o(err_o),
    .is_decoding_i(is_decoding_i), .read_regs_i(read_regs_i),
    .read_regs_valid_i(read_regs_valid_i), .read_dep_o(read_dep_o),
    .write_regs_i(write_regs_i), .write_regs_valid_i(write_regs_valid_i),
    .write_dep_o(write_dep_o),
    .perf_type_o(perf_type_o), .perf_cont_o(perf_cont_o), .perf_full_o(perf_full_o),
    .apu_master(apu_if)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [ADDR_W-1:0] mq[$];
  int                m_last_lat = 0;
  bit                m_err = 0;
  logic [ADDR_W-1:0] exp_q[$];

  logic [ADDR_W-1:0] rr [N_RD];
  logic [ADDR_W-1:0] wr [N_WR];
  logic [N_RD-1:0]   rrv = '0;
  logic [N_WR-1:0]   wrv = '0;
  logic              dec = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every writeback must match the oldest expected one
  always @(negedge clk) begin
    if (!rst_i) begin
      if (apu_wvalid_o) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wb_spurious: got waddr %0d expected no writeback (t=%0t)", apu_waddr_o, $time);
        end else begin
          logic [ADDR_W-1:0] e;
          e = exp_q.pop_front();
          if (apu_waddr_o !== e) begin
            fails++;
            $display("FAIL wb_addr: got %0d expected %0d (t=%0t)", apu_waddr_o, e, $time);
          end
        end
      end else if (exp_q.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL wb_missing: got no writeback expected waddr %0d (t=%0t)", exp_q[0], $time);
        exp_q.delete();
      end
    end
  end

  function automatic bit in_list(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l[$]);
    foreach (l[i]) if (l[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1; enable_i = 1'b0; apu_if.gnt = 1'b0; apu_if.valid = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    mq.delete(); exp_q.delete();
    m_last_lat = 0; m_err = 0;
  endtask

  // driver: one cycle of stimulus, model prediction, and status checks
  task automatic step(input logic en, input logic [1:0] lat, input logic [ADDR_W-1:0] wa,
                      input logic g, input logic v);
    int sz;
    bit act, st_type, st_full, vreq, acc, nack, single, popping, rdep, wdep;
    logic [ADDR_W-1:0] lv[$];
    @(posedge clk); #1;
    enable_i = en; apu_lat_i = lat; apu_waddr_i = wa;
    apu_if.gnt = g; apu_if.valid = v; is_decoding_i = dec;
    read_regs_valid_i = rrv; write_regs_valid_i = wrv;
    for (int k = 0; k < N_RD; k++) read_regs_i[k*ADDR_W +: ADDR_W] = rr[k];
    for (int k = 0; k < N_WR; k++) write_regs_i[k*ADDR_W +: ADDR_W] = wr[k];

    sz      = mq.size();
    act     = (sz != 0);
    st_type = en && act && (lat == 1 || (lat == 2 && m_last_lat == 3) || m_last_lat == 0 || lat == 0);
    st_full = en && (sz == DEPTH);
    vreq    = en && !st_type && !st_full;
    acc     = vreq && g;
    nack    = vreq && !g;
    single  = acc && v && (sz == 0);
    popping = v && (sz != 0);
    if (popping)     exp_q.push_back(mq[0]);
    else if (single) exp_q.push_back(wa);

    lv.delete();
    for (int i = (popping ? 1 : 0); i < sz; i++) lv.push_back(mq[i]);
    if (vreq && !single) lv.push_back(wa);
    rdep = 0; wdep = 0;
    for (int k = 0; k < N_RD; k++) if (rrv[k] && in_list(rr[k], lv)) rdep = 1;
    for (int k = 0; k < N_WR; k++) if (wrv[k] && in_list(wr[k], lv)) wdep = 1;
    rdep = rdep && dec;
    wdep = wdep && dec;

    @(negedge clk);
    chk("count",       int'(count_o),           sz);
    chk("active",      int'(active_o),          int'(act));
    chk("stall",       int'(stall_o),           int'(st_type || st_full || nack));
    chk("perf_type",   int'(perf_type_o),       int'(st_type));
    chk("perf_full",   int'(perf_full_o),       int'(st_full));
    chk("perf_cont",   int'(perf_cont_o),       int'(nack));
    chk("req",         int'(apu_if.req),        int'(vreq));
    chk("ready",       int'(apu_if.ready),      1);
    chk("read_dep",    int'(read_dep_o),        int'(rdep));
    chk("write_dep",   int'(write_dep_o),       int'(wdep));
    chk("err",         int'(err_o),             int'(m_err));
    chk("multicycle",  int'(apu_multicycle_o),  int'(m_last_lat == 3 || (m_last_lat == 0 && act)));
    chk("singlecycle", int'(apu_singlecycle_o), int'(!act));

    if (popping) void'(mq.pop_front());
    if (acc && !single) mq.push_back(wa);
    if (acc) m_last_lat = int'(lat);
    if (v && sz == 0 && !acc) m_err = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N_RD; k++) rr[k] = '0;
    for (int k = 0; k < N_WR; k++) wr[k] = '0;
    apu_if.gnt = 1'b0; apu_if.valid = 1'b0;
    do_reset();

    // reset state
    step(0, 0, 0, 0, 0);
    chk("rst_wvalid", int'(apu_wvalid_o), 0);
    chk("rst_waddr",  int'(apu_waddr_o), 0);

    // single-cycle return with empty queue
    step(1, 1, 5, 1, 1);
    chk("single_waddr", int'(apu_waddr_o), 5);
    step(0, 0, 0, 0, 0);
    chk("single_count", int'(count_o), 0);

    // fill to full, then drain in order
    for (int i = 1; i <= 4; i++) step(1, 3, ADDR_W'(i), 1, 0);
    step(1, 3, 10, 1, 0);
    chk("full_count", int'(count_o), 4);
    chk("full_perf",  int'(perf_full_o), 1);
    chk("full_req",   int'(apu_if.req), 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 1);
      chk("drain_addr", int'(apu_waddr_o), i);
    end

    // simultaneous push/pop across pointer wrap
    for (int i = 0; i < 3; i++) step(1, 3, ADDR_W'(11 + i), 1, 0);
    for (int i = 0; i < 6; i++) step(1, 3, 9, 1, 1);
    chk("wrap_count", int'(count_o), 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    // dependency with and without head pop
    do_reset();
    step(1, 3, 7, 1, 0);
    rr[2] = 7; rrv = 3'b100; wr[1] = 7; wrv = 2'b10; dec = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("dep_read_live", int'(read_dep_o), 1);
    step(0, 0, 0, 0, 1);
    chk("dep_read_pop", int'(read_dep_o), 0);
    rrv = '0; wrv = '0; dec = 1'b0;

    // latency-type stall, then grant contention on empty queue
    step(1, 3, 20, 1, 0);
    step(1, 2, 21, 1, 0);
    chk("type_perf", int'(perf_type_o), 1);
    step(0, 0, 0, 0, 1);
    step(1, 2, 22, 0, 0);
    chk("nack_cont", int'(perf_cont_o), 1);
    chk("nack_req",  int'(apu_if.req), 1);

    // spurious response sets sticky error; reset clears it
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("err_sticky", int'(err_o), 1);
    step(1, 3, 30, 1, 0);
    step(1, 3, 31, 1, 0);
    do_reset();
    step(0, 0, 0, 0, 0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_err",   int'(err_o), 0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset();
      for (int k = 0; k < N_RD; k++) rr[k] = ADDR_W'($urandom_range(0, 7));
      for (int k = 0; k < N_WR; k++) wr[k] = ADDR_W'($urandom_range(0, 7));
      rrv = N_RD'($urandom_range(0, 7));
      wrv = N_WR'($urandom_range(0, 3));
      dec = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           ADDR_W'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0));
    end

    @(posedge clk); #1;
    enable_i = 1'b0; apu_if.valid = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
